fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction-fetch stage for the pipelined MIPS CPU, replacing the bare PC-register / instruction-memory / IF-register chain. It issues sequential fetches to a 1-cycle-latency instruction memory and buffers returned instructions in a DEPTH-entry queue. Decode consumes the queue through a valid/ready handshake. A redirect port from execute flushes the queue and in-flight fetches; optional predecode adds static backward-taken branch prediction.

## Interface
- AW, 32: instruction address width; must be ≥ 3.
- DEPTH, 4: queue entries; power of two, ≥ 2.
- RESET_PC, 0: fetch address after reset; word aligned.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  AW  fetch address; low two bits are always 0.
- imem_rdata  in  32  instruction for the request issued in the previous cycle.
- if_valid  out  1  queue head is valid.
- if_instr  out  32  head instruction.
- if_pcplus4  out  AW  head PC + 4.
- if_pred_taken  out  1  head was predicted taken by predecode.
- id_ready  in  1  decode accepts the head this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  AW  restart address.
- occupancy  out  $clog2(DEPTH)+1  queue entry count.

## Operation
- State:
  - fetch_pc: next address to fetch.
  - pending: a request was issued in the previous cycle.
  - squash: the pending response must be dropped.
  - queue of {instr, pcplus4, pred_taken}.
- Issue rule: imem_req = !reset && !redirect && (occupancy + pending) < DEPTH.
  - imem_addr = fetch_pc.
  - On issue, fetch_pc <= fetch_pc + 4, modulo 2^AW; wrap is silent.
- Response: when pending && !squash, enqueue {imem_rdata, addr_of_pending + 4, pred}. Space is guaranteed by the issue rule.
- Dequeue: on if_valid && id_ready.
  - Enqueue and dequeue in the same cycle leave occupancy unchanged.
  - A full queue with simultaneous dequeue does not issue a new request that cycle; the issue rule uses the pre-edge occupancy.
- Redirect has highest priority:
  - queue cleared;
  - pending response squashed;
  - fetch_pc <= redirect_pc;
  - no issue that cycle;
  - no dequeue takes effect, even if id_ready is high.
- A redirect in consecutive cycles applies the last redirect_pc.
- Reset mid-operation behaves like redirect to RESET_PC, and also clears pending and squash.

## Timing
- Reset values:
  - imem_req = 0, if_valid = 0, if_instr = 0, if_pcplus4 = 0, if_pred_taken = 0, occupancy = 0.
  - fetch_pc = RESET_PC; pending and squash cleared.
- First imem_req with imem_addr = RESET_PC occurs in the first cycle reset is low.
- Fetch-to-decode latency: request in cycle t, data arrives in t+1, enqueued at the end of t+1, head visible in t+2.
- Sustained throughput is 1 instruction/cycle when id_ready is held high.
- After redirect in cycle t: if_valid = 0 in t+1, request to redirect_pc in t+1, first new instruction visible in t+3.
- if_* outputs come from registers, with no combinational path from id_ready. if_valid depends only on occupancy.

## Configuration
- FETCH_BTFN_PREDICT_EN defined: combinational predecode of each accepted response.
  - A response with opcode BEQ or BNE and negative 16-bit offset is predicted taken.
  - Target = pc + 4 + (sign-extended imm << 2), truncated to AW.
  - At that edge: pred_taken = 1 is stored, fetch_pc <= target, and the already-issued sequential request is squashed.
  - An external redirect in the same cycle overrides the prediction.
- Undefined: no predecode; if_pred_taken is tied to 0; fetch is strictly sequential apart from redirects.

## Structure
- Shared package cpu_pkg holds:
  - OP_BEQ = 6'h04, OP_BNE = 6'h05;
  - the fetch-entry typedef {instr, pcplus4, pred_taken}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, full, empty, count) stores entries.
- fetch_queue_unit holds fetch_pc, pending, squash, the issue rule and predecode.

## Test plan
- Reset release, imem returns RESET_PC>>2 as the instruction, id_ready = 1:
  - requests to 0x0, 0x4, 0x8 in consecutive cycles;
  - if_valid first high 2 cycles after the first request, with if_pcplus4 = 0x4.
- id_ready = 0 with DEPTH = 4:
  - exactly 4 instructions queued, occupancy = 4, imem_req low thereafter;
  - after one dequeue, imem_req reasserts in the following cycle.
- Redirect to 0x100 while the queue holds 3 entries and a fetch is pending:
  - next cycle if_valid = 0;
  - the pending response is dropped;
  - the next request address is 0x100;
  - the first new if_pcplus4 = 0x104.
- fetch_pc = 2^AW − 4:
  - the next request address is 0x0;
  - the queued entry's if_pcplus4 = 0x0.
- With FETCH_BTFN_PREDICT_EN, a BEQ at 0x40 with imm = −4:
  - if_pred_taken = 1;
  - the 0x44 response is squashed;
  - the next request goes to 0x34.
- Reset asserted mid-stream with a full queue:
  - all outputs return to reset values next cycle;
  - the request to RESET_PC follows deassertion.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcodes and the fetch-queue entry layout.
package cpu_pkg;

   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;

   // Entry layout for the 32-bit address build; the queue stores the AW-wide equivalent.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcplus4;
      logic        pred_taken;
   } fetch_entry_t;

   function automatic logic is_cond_branch(input logic [31:0] instr);
      return (instr[31:26] == OP_BEQ) || (instr[31:26] == OP_BNE);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO of DEPTH (power of two) registered entries with flush.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: sequential fetch into a DEPTH-entry queue with redirect flush.
// Optional static backward-taken prediction when FETCH_BTFN_PREDICT_EN is defined.
module fetch_queue_unit
   import cpu_pkg::*;
#(
   parameter int            AW       = 32,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    imem_req,
   output logic [AW-1:0]           imem_addr,
   input  logic [31:0]             imem_rdata,
   output logic                    if_valid,
   output logic [31:0]             if_instr,
   output logic [AW-1:0]           if_pcplus4,
   output logic                    if_pred_taken,
   input  logic                    id_ready,
   input  logic                    redirect,
   input  logic [AW-1:0]           redirect_pc,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_BTFN_PREDICT_EN
   localparam int EW = 33 + AW;
`else
   localparam int EW = 32 + AW;
`endif

   logic [AW-1:0] fetch_pc;
   logic [AW-1:0] pend_pc;
   logic [AW-1:0] next_pc;
   logic [AW-1:0] pend_pcplus4;
   logic          pending;
   logic          squash;
   logic          issue;
   logic          accept;
   logic          predict;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [EW-1:0] fifo_wdata;
   logic [EW-1:0] fifo_rdata;

   // Handshake: the head transfers on a cycle where if_valid && id_ready and no redirect/reset.
   always_comb begin
      issue = !reset && !redirect &&
              (({1'b0, occupancy} + {{CW{1'b0}}, pending}) < (CW+1)'(DEPTH));
      accept       = pending && !squash && !redirect && !reset;
      pend_pcplus4 = pend_pc + AW'(4);
      fifo_push    = accept;
      fifo_pop     = !fifo_empty && id_ready && !redirect && !reset;
   end

   assign imem_req  = issue;
   assign imem_addr = {fetch_pc[AW-1:2], 2'b00};

`ifdef FETCH_BTFN_PREDICT_EN
   logic [AW-1:0] pred_target;

   always_comb begin
      predict     = accept && is_cond_branch(imem_rdata) && imem_rdata[15];
      pred_target = pend_pcplus4 +
                    AW'({{AW{imem_rdata[15]}}, imem_rdata[15:0], 2'b00});
      next_pc     = issue ? fetch_pc + AW'(4) : fetch_pc;
      if (predict) next_pc = pred_target;
      fifo_wdata  = {imem_rdata, pend_pcplus4, predict};
   end

   assign if_pred_taken = if_valid & fifo_rdata[0];
`else
   always_comb begin
      predict    = 1'b0;
      next_pc    = issue ? fetch_pc + AW'(4) : fetch_pc;
      fifo_wdata = {imem_rdata, pend_pcplus4};
   end

   assign if_pred_taken = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         pend_pc  <= RESET_PC;
         pending  <= 1'b0;
         squash   <= 1'b0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         pending  <= 1'b0;
         squash   <= 1'b0;
      end else begin
         fetch_pc <= next_pc;
         pending  <= issue;
         // The sequential request issued alongside a predicted branch is wrong-path.
         squash   <= issue && predict;
         if (issue) pend_pc <= imem_addr;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (redirect),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occupancy)
   );

   assign if_valid   = !fifo_empty;
   assign if_instr   = if_valid ? fifo_rdata[EW-1 -: 32] : 32'h0;
   assign if_pcplus4 = if_valid ? fifo_rdata[EW-33 -: AW] : '0;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit (AW=32, DEPTH=4, RESET_PC=0) with a 1-cycle imem model.
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pcplus4;
   logic        if_pred_taken;
   logic        id_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  occupancy;

   int tests_run    = 0;
   int tests_failed = 0;
   bit beq_en       = 1'b0;

   localparam logic [31:0] BEQ_WORD = {6'h04, 5'd1, 5'd2, 16'hFFFC};

   fetch_queue_unit #(.AW(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_instr      (if_instr),
      .if_pcplus4    (if_pcplus4),
      .if_pred_taken (if_pred_taken),
      .id_ready      (id_ready),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .occupancy     (occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (beq_en && a == 32'h40) return BEQ_WORD;
      return a >> 2;
   endfunction

   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic rdy);
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = rdy;
      repeat (2) cyc();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
      repeat (3) cyc();
      #1;
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", if_valid); end
      tests_run++; if (if_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want 0", if_instr); end
      tests_run++; if (if_pcplus4 !== 32'h0) begin tests_failed++; $display("FAIL reset_pcplus4: got %h want 0", if_pcplus4); end
      tests_run++; if (if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_pred: got %b want 0", if_pred_taken); end
      tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
   endtask

   task automatic test_stream();
      reset = 1'b0;
      #1;
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL stream_req0: got %b/%h want 1/0", imem_req, imem_addr); end
      cyc(); #1;
      tests_run++; if (imem_addr !== 32'h4 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_c1: got addr %h valid %b want 4/0", imem_addr, if_valid); end
      cyc(); #1;
      tests_run++; if (imem_addr !== 32'h8) begin tests_failed++; $display("FAIL stream_addr2: got %h want 8", imem_addr); end
      tests_run++; if (if_valid !== 1'b1 || if_pcplus4 !== 32'h4 || if_instr !== 32'h0) begin tests_failed++; $display("FAIL stream_head0: got v%b pc4 %h i %h want 1/4/0", if_valid, if_pcplus4, if_instr); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b1 || if_pcplus4 !== 32'h8 || if_instr !== 32'h1 || occupancy !== 3'd1) begin tests_failed++; $display("FAIL stream_head1: got v%b pc4 %h i %h occ %0d want 1/8/1/1", if_valid, if_pcplus4, if_instr, occupancy); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b1 || if_pcplus4 !== 32'hC || if_instr !== 32'h2) begin tests_failed++; $display("FAIL stream_head2: got v%b pc4 %h i %h want 1/c/2", if_valid, if_pcplus4, if_instr); end
   endtask

   task automatic test_backpressure();
      apply_reset(1'b0);
      repeat (5) cyc();
      #1;
      tests_run++; if (occupancy !== 3'd4) begin tests_failed++; $display("FAIL bp_occ_full: got %0d want 4", occupancy); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
      tests_run++; if (if_instr !== 32'h0 || if_pcplus4 !== 32'h4) begin tests_failed++; $display("FAIL bp_head: got %h/%h want 0/4", if_instr, if_pcplus4); end
      cyc(); id_ready = 1'b1; #1;
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_req_pop_full: got %b want 0", imem_req); end
      cyc(); id_ready = 1'b0; #1;
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin tests_failed++; $display("FAIL bp_reissue: got %b/%h want 1/10", imem_req, imem_addr); end
      tests_run++; if (occupancy !== 3'd3 || if_instr !== 32'h1 || if_pcplus4 !== 32'h8) begin tests_failed++; $display("FAIL bp_after_pop: got occ %0d i %h pc4 %h want 3/1/8", occupancy, if_instr, if_pcplus4); end
   endtask

   task automatic test_redirect();
      apply_reset(1'b0);
      repeat (4) cyc();
      redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      tests_run++; if (occupancy !== 3'd3 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL redir_setup: got occ %0d req %b want 3/0", occupancy, imem_req); end
      cyc(); redirect = 1'b0; #1;
      tests_run++; if (if_valid !== 1'b0 || occupancy !== 3'd0) begin tests_failed++; $display("FAIL redir_flush: got v%b occ %0d want 0/0", if_valid, occupancy); end
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin tests_failed++; $display("FAIL redir_req: got %b/%h want 1/100", imem_req, imem_addr); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b0 || occupancy !== 3'd0 || imem_addr !== 32'h104) begin tests_failed++; $display("FAIL redir_drop: got v%b occ %0d addr %h want 0/0/104", if_valid, occupancy, imem_addr); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b1 || if_pcplus4 !== 32'h104 || if_instr !== 32'h40) begin tests_failed++; $display("FAIL redir_first: got v%b pc4 %h i %h want 1/104/40", if_valid, if_pcplus4, if_instr); end
   endtask

   task automatic test_back_to_back_redirect();
      cyc(); redirect = 1'b1; redirect_pc = 32'h200; #1;
      cyc(); redirect_pc = 32'h300; #1;
      tests_run++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_hold: got req %b v%b want 0/0", imem_req, if_valid); end
      cyc(); redirect = 1'b0; #1;
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin tests_failed++; $display("FAIL b2b_req: got %b/%h want 1/300", imem_req, imem_addr); end
      cyc(); #1;
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b1 || if_pcplus4 !== 32'h304 || if_instr !== 32'hC0) begin tests_failed++; $display("FAIL b2b_first: got v%b pc4 %h i %h want 1/304/c0", if_valid, if_pcplus4, if_instr); end
   endtask

   task automatic test_wrap();
      id_ready = 1'b1;
      cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      cyc(); redirect = 1'b0; #1;
      tests_run++; if (imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_top: got %h want fffffffc", imem_addr); end
      cyc(); #1;
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr: got %b/%h want 1/0", imem_req, imem_addr); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b1 || if_pcplus4 !== 32'h0 || if_instr !== 32'h3FFF_FFFF) begin tests_failed++; $display("FAIL wrap_pc4: got v%b pc4 %h i %h want 1/0/3fffffff", if_valid, if_pcplus4, if_instr); end
      cyc(); #1;
      tests_run++; if (if_pcplus4 !== 32'h4 || if_instr !== 32'h0) begin tests_failed++; $display("FAIL wrap_next: got pc4 %h i %h want 4/0", if_pcplus4, if_instr); end
   endtask

   task automatic test_predict();
      id_ready = 1'b1;
      cyc(); beq_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; #1;
      cyc(); redirect = 1'b0; #1;
      tests_run++; if (imem_addr !== 32'h40) begin tests_failed++; $display("FAIL pred_req40: got %h want 40", imem_addr); end
      cyc(); #1;
      tests_run++; if (imem_addr !== 32'h44 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL pred_req44: got %h v%b want 44/0", imem_addr, if_valid); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b1 || if_instr !== BEQ_WORD || if_pcplus4 !== 32'h44) begin tests_failed++; $display("FAIL pred_head: got v%b i %h pc4 %h want 1/%h/44", if_valid, if_instr, if_pcplus4, BEQ_WORD); end
`ifdef FETCH_BTFN_PREDICT_EN
      tests_run++; if (if_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL pred_taken: got %b want 1", if_pred_taken); end
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h34) begin tests_failed++; $display("FAIL pred_target: got %b/%h want 1/34", imem_req, imem_addr); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b0 || imem_addr !== 32'h38) begin tests_failed++; $display("FAIL pred_squash: got v%b addr %h want 0/38", if_valid, imem_addr); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b1 || if_pcplus4 !== 32'h38 || if_instr !== 32'hD || if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL pred_newpath: got v%b pc4 %h i %h p%b want 1/38/d/0", if_valid, if_pcplus4, if_instr, if_pred_taken); end
`else
      tests_run++; if (if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL nopred_taken: got %b want 0", if_pred_taken); end
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h48) begin tests_failed++; $display("FAIL nopred_seq: got %b/%h want 1/48", imem_req, imem_addr); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b1 || if_pcplus4 !== 32'h48 || if_instr !== 32'h11) begin tests_failed++; $display("FAIL nopred_next: got v%b pc4 %h i %h want 1/48/11", if_valid, if_pcplus4, if_instr); end
`endif
      beq_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      id_ready = 1'b0;
      cyc(); redirect = 1'b1; redirect_pc = 32'h20; #1;
      cyc(); redirect = 1'b0; #1;
      repeat (5) cyc();
      #1;
      tests_run++; if (occupancy !== 3'd4 || if_pcplus4 !== 32'h24) begin tests_failed++; $display("FAIL rmid_full: got occ %0d pc4 %h want 4/24", occupancy, if_pcplus4); end
      cyc(); reset = 1'b1; #1;
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rmid_req_in_reset: got %b want 0", imem_req); end
      cyc(); #1;
      tests_run++; if (if_valid !== 1'b0 || occupancy !== 3'd0) begin tests_failed++; $display("FAIL rmid_clear: got v%b occ %0d want 0/0", if_valid, occupancy); end
      tests_run++; if (if_instr !== 32'h0 || if_pcplus4 !== 32'h0 || if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL rmid_outs: got %h/%h/%b want 0/0/0", if_instr, if_pcplus4, if_pred_taken); end
      cyc(); reset = 1'b0; #1;
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL rmid_restart: got %b/%h want 1/0", imem_req, imem_addr); end
      cyc(); #1;
      tests_run++; if (imem_addr !== 32'h4 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_seq: got %h v%b want 4/0", imem_addr, if_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_back_to_back_redirect();
      test_wrap();
      test_predict();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
